// File: rtl/bulk_sie_port.sv
`default_nettype none
// ============================================================================
// Module      : bulk_sie_port
// Description : SIE-side initiator of the bulk IN/OUT endpoint handshake.
//               Converts decoded token/data/handshake events into endpoint
//               strobes and sources IN bytes to the packet transmitter.
// Ports       : clk_i/rst_i         clock, asynchronous active-high reset
//               token_in_i/out_i    IN/OUT token pulses for this endpoint
//               hs_ack_i/timeout_i  host ACK after IN data / handshake timeout
//               rx_*                OUT data byte stream, end and error pulses
//               tx_*                IN byte stream to the transmitter + EOP
//               hs_valid_o/hs_nak_o handshake request to the transmitter
//               ep_in_*             endpoint IN side (req/ready/data/ack)
//               ep_out_*            endpoint OUT side (data/valid/err/ready/nak)
// Revision    : 1.0 - initial release
// ============================================================================
module bulk_sie_port #(
  parameter int IN_MAXPACKETSIZE  = 8,
  parameter int OUT_MAXPACKETSIZE = 8,
  parameter int IN_LAT            = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       token_in_i,
  input  logic       token_out_i,
  input  logic       hs_ack_i,
  input  logic       timeout_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_end_i,
  input  logic       rx_err_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       tx_eop_o,
  output logic       hs_valid_o,
  output logic       hs_nak_o,
  output logic       ep_in_req_o,
  output logic       ep_in_ready_o,
  output logic       ep_in_data_ack_o,
  input  logic [7:0] ep_in_data_i,
  input  logic       ep_in_valid_i,
  output logic [7:0] ep_out_data_o,
  output logic       ep_out_valid_o,
  output logic       ep_out_err_o,
  output logic       ep_out_ready_o,
  input  logic       ep_out_nak_i
);

  localparam int IN_CW  = $clog2(IN_MAXPACKETSIZE + 1);
  localparam int OUT_CW = $clog2(OUT_MAXPACKETSIZE + 1);
  localparam int LAT_CW = $clog2(IN_LAT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    IN_SETTLE = 3'd1,
    IN_DATA   = 3'd2,
    IN_HS     = 3'd3,
    OUT_DATA  = 3'd4,
    OUT_END   = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [IN_CW-1:0]    in_cnt, in_cnt_nxt;
  logic [OUT_CW-1:0]   out_cnt, out_cnt_nxt;
  logic [LAT_CW-1:0]   settle, settle_nxt;
  // OUT byte pipeline phase: 0 idle, 1 = data presented, 2 = data + ready
  logic [1:0]          out_ph, out_ph_nxt;
  logic                err_pend, err_pend_nxt;
  logic                end_pend, end_pend_nxt;

  logic [7:0] tx_data_nxt, ep_out_data_nxt;
  logic       tx_valid_nxt, tx_eop_nxt, hs_valid_nxt, hs_nak_nxt;
  logic       ep_in_req_nxt, ep_in_data_ack_nxt;
  logic       ep_out_valid_nxt, ep_out_err_nxt, ep_out_ready_nxt;
  logic       token_any, err_now, end_now;

  assign token_any = token_in_i | token_out_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      in_cnt           <= '0;
      out_cnt          <= '0;
      settle           <= '0;
      out_ph           <= 2'd0;
      err_pend         <= 1'b0;
      end_pend         <= 1'b0;
      tx_data_o        <= 8'd0;
      tx_valid_o       <= 1'b0;
      tx_eop_o         <= 1'b0;
      hs_valid_o       <= 1'b0;
      hs_nak_o         <= 1'b0;
      ep_in_req_o      <= 1'b0;
      ep_in_data_ack_o <= 1'b0;
      ep_out_data_o    <= 8'd0;
      ep_out_valid_o   <= 1'b0;
      ep_out_err_o     <= 1'b0;
      ep_out_ready_o   <= 1'b0;
    end else begin
      state            <= state_nxt;
      in_cnt           <= in_cnt_nxt;
      out_cnt          <= out_cnt_nxt;
      settle           <= settle_nxt;
      out_ph           <= out_ph_nxt;
      err_pend         <= err_pend_nxt;
      end_pend         <= end_pend_nxt;
      tx_data_o        <= tx_data_nxt;
      tx_valid_o       <= tx_valid_nxt;
      tx_eop_o         <= tx_eop_nxt;
      hs_valid_o       <= hs_valid_nxt;
      hs_nak_o         <= hs_nak_nxt;
      ep_in_req_o      <= ep_in_req_nxt;
      ep_in_data_ack_o <= ep_in_data_ack_nxt;
      ep_out_data_o    <= ep_out_data_nxt;
      ep_out_valid_o   <= ep_out_valid_nxt;
      ep_out_err_o     <= ep_out_err_nxt;
      ep_out_ready_o   <= ep_out_ready_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    in_cnt_nxt         = in_cnt;
    out_cnt_nxt        = out_cnt;
    settle_nxt         = settle;
    out_ph_nxt         = out_ph;
    err_pend_nxt       = err_pend;
    end_pend_nxt       = end_pend;
    tx_data_nxt        = tx_data_o;
    tx_valid_nxt       = tx_valid_o;
    tx_eop_nxt         = 1'b0;
    hs_valid_nxt       = 1'b0;
    hs_nak_nxt         = 1'b0;
    ep_in_req_nxt      = ep_in_req_o;
    ep_in_data_ack_nxt = 1'b0;
    ep_out_data_nxt    = ep_out_data_o;
    ep_out_valid_nxt   = 1'b0;
    ep_out_err_nxt     = 1'b0;
    ep_out_ready_nxt   = 1'b0;
    ep_in_ready_o      = 1'b0;
    err_now            = 1'b0;
    end_now            = 1'b0;

    case (state)
      IDLE: begin
        // req is held through the ACK pulse cycle and dropped here
        ep_in_req_nxt = 1'b0;
        tx_valid_nxt  = 1'b0;
        out_ph_nxt    = 2'd0;
        err_pend_nxt  = 1'b0;
        end_pend_nxt  = 1'b0;
        if (token_in_i && !token_out_i) begin
          ep_in_req_nxt = 1'b1;
          in_cnt_nxt    = '0;
          settle_nxt    = '0;
          state_nxt     = IN_SETTLE;
        end else if (token_out_i && !token_in_i) begin
          out_cnt_nxt = '0;
          state_nxt   = OUT_DATA;
        end
      end

      IN_SETTLE: begin
        if (token_any) begin
          ep_in_req_nxt = 1'b0;
          state_nxt     = IDLE;
        end else if (settle == LAT_CW'(IN_LAT - 1)) begin
          state_nxt = IN_DATA;
        end else begin
          settle_nxt = settle + 1'b1;
        end
      end

      IN_DATA: begin
        if (token_any) begin
          ep_in_req_nxt = 1'b0;
          tx_valid_nxt  = 1'b0;
          state_nxt     = IDLE;
        end else if (tx_valid_o) begin
          if (tx_ready_i) begin
            ep_in_ready_o = 1'b1;
            tx_valid_nxt  = 1'b0;
            in_cnt_nxt    = in_cnt + 1'b1;
            settle_nxt    = '0;
            state_nxt     = IN_SETTLE;
          end
        end else if (ep_in_valid_i && (in_cnt < IN_CW'(IN_MAXPACKETSIZE))) begin
          tx_data_nxt  = ep_in_data_i;
          tx_valid_nxt = 1'b1;
        end else begin
          // short packet, ZLP, or max-size reached: close the packet
          tx_eop_nxt = 1'b1;
          state_nxt  = IN_HS;
        end
      end

      IN_HS: begin
        if (token_any || timeout_i) begin
          ep_in_req_nxt = 1'b0;
          state_nxt     = IDLE;
        end else if (hs_ack_i) begin
          ep_in_data_ack_nxt = 1'b1;
          ep_out_ready_nxt   = 1'b1;
          state_nxt          = IDLE;
        end
      end

      OUT_DATA: begin
        err_now = err_pend;
        end_now = end_pend | rx_end_i;
        if (out_ph == 2'd1)      out_ph_nxt = 2'd2;
        else if (out_ph == 2'd2) out_ph_nxt = 2'd0;

        if (token_any || rx_err_i) begin
          err_now = 1'b1;
        end else if (rx_valid_i) begin
          // overlapping byte or babble beyond max packet size
          if ((out_ph != 2'd0) || (out_cnt == OUT_CW'(OUT_MAXPACKETSIZE))) begin
            err_now = 1'b1;
          end else begin
            ep_out_data_nxt = rx_data_i;
            out_ph_nxt      = 2'd1;
            out_cnt_nxt     = out_cnt + 1'b1;
          end
        end

        ep_out_valid_nxt = (out_ph_nxt != 2'd0);
        ep_out_ready_nxt = (out_ph_nxt == 2'd2);

        // terminate only once no byte is in flight
        if ((out_ph == 2'd0) && (out_ph_nxt == 2'd0) && err_now) begin
          ep_out_ready_nxt = 1'b1;
          ep_out_err_nxt   = 1'b1;
          state_nxt        = IDLE;
        end else if ((out_ph == 2'd0) && (out_ph_nxt == 2'd0) && end_now) begin
          state_nxt = OUT_END;
        end else begin
          err_pend_nxt = err_now;
          end_pend_nxt = end_now;
        end
      end

      OUT_END: begin
        ep_out_ready_nxt = 1'b1;
        state_nxt        = IDLE;
        if (token_any) begin
          ep_out_err_nxt = 1'b1;
        end else begin
          hs_valid_nxt = 1'b1;
          hs_nak_nxt   = ep_out_nak_i;
        end
      end

      default: begin
        ep_in_req_nxt = 1'b0;
        tx_valid_nxt  = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
